// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment table, blank code,
// FSM state encoding and the decoded-pattern record.
package seg7_scan_decoder_pkg;

   localparam int SEG_W          = 7;
   localparam int DEF_NUM_DIGITS = 8;

   // Active-high segment patterns, bit0=a .. bit6=g; index = hex value shown.
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic [1:0] {
      WAIT_SEL = 2'd0,
      SETTLE   = 2'd1,
      HELD     = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic       hit;
      logic       blank;
      logic [3:0] nibble;
   } seg_decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-high segment pattern back to its hex nibble,
// flagging blank and unknown patterns.
module seg7_pattern_decode
   import seg7_scan_decoder_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output seg_decode_t      dec
);

   always_comb begin
      dec       = '0;
      dec.blank = (seg == SEG_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (seg == HEX_SEG[i]) begin
            dec.hit    = 1'b1;
            dec.nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment scan bus: waits for each digit's
// pattern to settle, decodes it and rebuilds the displayed value.
module seg7_scan_decoder
   import seg7_scan_decoder_pkg::*;
#(
   parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
   parameter int SETTLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [SEG_W-1:0]        seg_in,
   input  logic [NUM_DIGITS-1:0]   en_in,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] value_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    bad_pattern,
   output logic [2:0]              bad_index,
   output logic                    stalled
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SEG_W-1:0]        seg_raw_q, seg_raw_d;
   logic [NUM_DIGITS-1:0]   en_raw_q, en_raw_d;
   logic [SEG_W-1:0]        seg_n;
   logic [NUM_DIGITS-1:0]   en_n;
   logic                    sel_valid;
   logic [IDX_W-1:0]        sel_idx;
   seg_decode_t             dec;

   scan_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        cur_idx_q, cur_idx_d;
   logic [SEG_W-1:0]        cur_seg_q, cur_seg_d;
   logic                    same_pair;
   logic                    start_dwell;
   logic                    capture;

   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [NUM_DIGITS-1:0]   seen_set;
   logic                    frame_q, frame_d;
   logic                    bad_q, bad_d;
   logic [2:0]              bad_idx_q, bad_idx_d;
   logic [IDLE_W-1:0]       idle_q, idle_d;
   logic                    stalled_q, stalled_d;

   assign seg_raw_d = seg_in;
   assign en_raw_d  = en_in;
   assign seg_n     = SEG_ACTIVE_LOW ? ~seg_raw_q : seg_raw_q;
   assign en_n      = EN_ACTIVE_LOW  ? ~en_raw_q  : en_raw_q;

   // Exactly one enable set: nonzero and no second bit left after clearing the lowest.
   assign sel_valid = (en_n != '0) && ((en_n & (en_n - NUM_DIGITS'(1))) == '0);

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en_n[i]) sel_idx = IDX_W'(i);
      end
   end

   seg7_pattern_decode u_decode (
      .seg (seg_n),
      .dec (dec)
   );

   assign same_pair = (sel_idx == cur_idx_q) && (seg_n == cur_seg_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_idx_d   = cur_idx_q;
      cur_seg_d   = cur_seg_q;
      capture     = 1'b0;
      start_dwell = 1'b0;
      if (!sel_valid) begin
         state_d = WAIT_SEL;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            WAIT_SEL: start_dwell = 1'b1;
            SETTLE: begin
               if (!same_pair) begin
                  start_dwell = 1'b1;
               end else if (cnt_q + CNT_W'(1) == CNT_W'(SETTLE_CYCLES)) begin
                  capture = 1'b1;
                  state_d = HELD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            HELD: start_dwell = !same_pair;
            default: state_d = WAIT_SEL;
         endcase
         // A new pair counts as its first stable sample.
         if (start_dwell) begin
            cur_idx_d = sel_idx;
            cur_seg_d = seg_n;
            cnt_d     = CNT_W'(1);
            if (SETTLE_CYCLES <= 1) begin
               capture = 1'b1;
               state_d = HELD;
            end else begin
               state_d = SETTLE;
            end
         end
      end
      if (clear) begin
         state_d = WAIT_SEL;
         cnt_d   = '0;
         capture = 1'b0;
      end
   end

   assign seen_set = seen_q | (NUM_DIGITS'(1) << sel_idx);

   always_comb begin
      value_d   = value_q;
      valid_d   = valid_q;
      seen_d    = seen_q;
      frame_d   = 1'b0;
      bad_d     = bad_q;
      bad_idx_d = bad_idx_q;
      idle_d    = idle_q;
      stalled_d = stalled_q;
      if (clear) begin
         value_d   = '0;
         valid_d   = '0;
         seen_d    = '0;
         bad_d     = 1'b0;
         bad_idx_d = '0;
         idle_d    = '0;
         stalled_d = 1'b0;
      end else if (capture) begin
         idle_d    = '0;
         stalled_d = 1'b0;
         if (dec.hit || dec.blank) begin
            value_d[4*sel_idx +: 4] = dec.hit ? dec.nibble : 4'h0;
            valid_d[sel_idx]        = dec.hit;
            if (&seen_set) begin
               frame_d = 1'b1;
               seen_d  = '0;
            end else begin
               seen_d = seen_set;
            end
         end else begin
            bad_d     = 1'b1;
            bad_idx_d = 3'(sel_idx);
         end
      end else begin
         if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) idle_d = idle_q + IDLE_W'(1);
         stalled_d = (idle_d == IDLE_W'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         seg_raw_q <= '0;
         en_raw_q  <= '0;
         state_q   <= WAIT_SEL;
         cnt_q     <= '0;
         cur_idx_q <= '0;
         cur_seg_q <= '0;
         value_q   <= '0;
         valid_q   <= '0;
         seen_q    <= '0;
         frame_q   <= 1'b0;
         bad_q     <= 1'b0;
         bad_idx_q <= '0;
         idle_q    <= '0;
         stalled_q <= 1'b0;
      end else begin
         seg_raw_q <= seg_raw_d;
         en_raw_q  <= en_raw_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_idx_q <= cur_idx_d;
         cur_seg_q <= cur_seg_d;
         value_q   <= value_d;
         valid_q   <= valid_d;
         seen_q    <= seen_d;
         frame_q   <= frame_d;
         bad_q     <= bad_d;
         bad_idx_q <= bad_idx_d;
         idle_q    <= idle_d;
         stalled_q <= stalled_d;
      end
   end

   assign value_out   = value_q;
   assign digit_valid = valid_q;
   assign frame_done  = frame_q;
   assign bad_pattern = bad_q;
   assign bad_index   = bad_idx_q;
   assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised and directed bench for seg7_scan_decoder: a run-length reference
// model predicts every cycle's outputs and a monitor compares them.
module tb_seg7_scan_decoder;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 1024;

   typedef struct packed {
      logic [31:0] val;
      logic [7:0]  dv;
      logic        fd;
      logic        bp;
      logic [2:0]  bi;
      logic        st;
   } obs_t;

   logic        Clk, Rst, clear;
   logic [6:0]  seg_in;
   logic [7:0]  en_in;
   logic [31:0] value_out;
   logic [7:0]  digit_valid;
   logic        frame_done, bad_pattern, stalled;
   logic [2:0]  bad_index;

   obs_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   fd_count = 0;

   logic [6:0] hex_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   seg7_scan_decoder dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .seg_in      (seg_in),
      .en_in       (en_in),
      .clear       (clear),
      .value_out   (value_out),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .bad_pattern (bad_pattern),
      .bad_index   (bad_index),
      .stalled     (stalled)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, checks=%0d", checks);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // Tracks how long the same single-digit (index, pattern) sample has persisted;
   // a capture happens exactly when that run length first reaches SETTLE.
   logic [31:0] m_val;
   logic [7:0]  m_dv, m_seen;
   logic        m_fd, m_bp, m_st;
   logic [2:0]  m_bi;
   int          m_idle, run, prev_idx;
   logic        prev_sel;
   logic [6:0]  prev_lit, s_seg;
   logic [7:0]  s_en;

   task automatic model_reset();
      m_val = '0; m_dv = '0; m_seen = '0; m_fd = 0; m_bp = 0; m_st = 0; m_bi = '0;
      m_idle = 0; run = 0; prev_idx = 0; prev_sel = 0; prev_lit = '0;
      s_seg = '0; s_en = '0;
   endtask

   task automatic model_step();
      logic [6:0] lit;
      logic [7:0] sel;
      int         idx, nib;
      logic       cap;
      m_fd = 1'b0;
      if (!Rst) begin
         model_reset();
      end else begin
         lit = ~s_seg;
         sel = ~s_en;
         cap = 1'b0;
         idx = 0;
         if (clear) begin
            m_val = '0; m_dv = '0; m_seen = '0; m_bp = 0; m_bi = '0;
            m_idle = 0; m_st = 0; run = 0; prev_sel = 0;
         end else begin
            if ($countones(sel) == 1) begin
               for (int i = 0; i < 8; i++) if (sel[i]) idx = i;
               if (prev_sel && idx == prev_idx && lit == prev_lit) run++;
               else run = 1;
               prev_sel = 1; prev_idx = idx; prev_lit = lit;
               cap = (run == SETTLE);
            end else begin
               run = 0; prev_sel = 0;
            end
            if (cap) begin
               m_idle = 0; m_st = 0;
               nib = -1;
               for (int v = 0; v < 16; v++) if (hex_tab[v] == lit) nib = v;
               if (nib >= 0 || lit == 7'h00) begin
                  m_val[idx*4 +: 4] = (nib >= 0) ? 4'(nib) : 4'h0;
                  m_dv[idx] = (nib >= 0);
                  m_seen[idx] = 1'b1;
                  if (m_seen == 8'hFF) begin
                     m_fd = 1'b1;
                     m_seen = '0;
                  end
               end else begin
                  m_bp = 1'b1;
                  m_bi = 3'(idx);
               end
            end else begin
               if (m_idle < TIMEOUT) m_idle++;
               m_st = (m_idle == TIMEOUT);
            end
         end
         s_seg = seg_in;
         s_en  = en_in;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge Clk);
         model_step();
         exp_q.push_back({m_val, m_dv, m_fd, m_bp, m_bi, m_st});
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      obs_t a, e;
      forever begin
         @(negedge Clk);
         a = {value_out, digit_valid, frame_done, bad_pattern, bad_index, stalled};
         if (a.fd) fd_count++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t actual=%h required=an expected entry", $time, a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               failures++;
               $display("FAIL cycle_outputs t=%0t val=%h/%h dv=%h/%h fd=%b/%b bp=%b/%b bi=%0d/%0d st=%b/%b (actual/required)",
                        $time, a.val, e.val, a.dv, e.dv, a.fd, e.fd, a.bp, e.bp, a.bi, e.bi, a.st, e.st);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, got, exp);
      end
   endtask

   task automatic apply(input logic [7:0] en, input logic [6:0] lit, input int cycles, input int clear_at);
      for (int c = 0; c < cycles; c++) begin
         en_in  = en;
         seg_in = ~lit;
         clear  = (c == clear_at);
         @(negedge Clk);
      end
      clear = 1'b0;
   endtask

   task automatic show_digit(input int d, input logic [6:0] lit, input int cycles, input int clear_at);
      logic [7:0] en;
      en = 8'h01 << d;
      apply(~en, lit, cycles, clear_at);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] lit;
      logic [7:0] en;
      int         kind, dwell, clr;
      Rst = 1'b0; clear = 1'b0; seg_in = 7'h7F; en_in = 8'hFF;
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      check_eq("reset_value", value_out, 32'h0);
      check_eq("reset_flags", {digit_valid, frame_done, bad_pattern, bad_index, stalled}, 32'h0);

      // Reset in the middle of a dwell abandons it.
      for (int d = 0; d < 3; d++) show_digit(d, hex_tab[d], 8, -1);
      check_eq("preload_value", value_out, 32'h0000_0210);
      show_digit(3, hex_tab[3], 3, -1);
      #2 Rst = 1'b0;
      #1;
      check_eq("async_rst_value", value_out, 32'h0);
      check_eq("async_rst_flags", {digit_valid, frame_done, bad_pattern, bad_index, stalled}, 32'h0);
      @(negedge Clk);
      Rst = 1'b1;
      show_digit(3, hex_tab[3], 4, -1);
      check_eq("redwell_4_edges", digit_valid, 8'h00);
      show_digit(3, hex_tab[3], 1, -1);
      check_eq("redwell_capture", value_out, 32'h0000_3000);

      // Capture lands on the 5th edge; an interrupted dwell captures nothing.
      show_digit(0, hex_tab[1], 4, -1);
      check_eq("dwell_before_5th", digit_valid, 8'h08);
      show_digit(0, hex_tab[1], 2, -1);
      check_eq("dwell_value", value_out[3:0], 4'h1);
      check_eq("dwell_valid", digit_valid, 8'h09);
      show_digit(1, hex_tab[2], 2, -1);
      show_digit(1, hex_tab[3], 2, -1);
      check_eq("interrupted_dwell", digit_valid, 8'h09);

      // Full scan of one frame.
      fd_count = 0;
      for (int d = 0; d < 8; d++) show_digit(d, hex_tab[d], 8, -1);
      check_eq("frame_value", value_out, 32'h7654_3210);
      check_eq("frame_valid", digit_valid, 8'hFF);
      check_eq("frame_pulses", fd_count, 1);

      // Unknown pattern, then clear.
      show_digit(3, 7'h49, 6, -1);
      check_eq("bad_flag", bad_pattern, 1'b1);
      check_eq("bad_index", bad_index, 3'd3);
      check_eq("bad_keeps_value", value_out, 32'h7654_3210);
      apply(8'hFF, 7'h00, 1, 0);
      check_eq("clear_flags", {digit_valid, frame_done, bad_pattern, bad_index, stalled}, 32'h0);
      check_eq("clear_value", value_out, 32'h0);

      // Two enables active: never a selection, so the idle timer runs out.
      apply(8'hFC, hex_tab[1], 1000, -1);
      check_eq("not_stalled_yet", stalled, 1'b0);
      apply(8'hFC, hex_tab[1], 1000, -1);
      check_eq("stalled", stalled, 1'b1);
      show_digit(0, hex_tab[5], 6, -1);
      check_eq("stall_cleared", stalled, 1'b0);
      check_eq("stall_capture", value_out, 32'h5);

      // Clear on the edge that would complete a frame.
      apply(8'hFF, 7'h00, 1, 0);
      fd_count = 0;
      for (int d = 0; d < 7; d++) show_digit(d, hex_tab[d + 8], 8, -1);
      show_digit(7, hex_tab[15], 8, 4);
      check_eq("clear_wins_value", value_out, 32'h0);
      check_eq("clear_wins_frame", fd_count, 0);

      // Random scan traffic, checked cycle by cycle by the scoreboard.
      for (int n = 0; n < 400; n++) begin
         kind  = $urandom_range(0, 9);
         dwell = $urandom_range(1, 9);
         clr   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, dwell - 1) : -1;
         en    = ~(8'h01 << $urandom_range(0, 7));
         lit   = hex_tab[$urandom_range(0, 15)];
         if (kind == 7) lit = 7'h00;
         if (kind == 8) lit = 7'($urandom_range(0, 127));
         if (kind == 9) en = 8'($urandom_range(0, 255));
         apply(en, lit, dwell, clr);
      end

      repeat (2) @(negedge Clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
